axi_depacketizer: RTL

AXI_DEPACKETIZER -- requirements
Module: axi_depacketizer

---
 rtl/axi_depacketizer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/axi_depacketizer.sv
// rtl/axi_depacketizer.sv - byte-stream packet depacketizer to 32-bit sample stream with metadata.
// Optional per-packet ok/error counters are built when `DEPKT_STATS_EN is defined.
module axi_depacketizer #(
  parameter logic [31:0] HDR_WORD = 32'h30415144,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic [7:0]        m_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              meta_valid,
  output logic [31:0]       pkt_timestamp,
  output logic [7:0]        pkt_len,
  output logic [15:0]       pkt_error_flags,
  output logic              pkt_done,
  output logic [1:0]        pkt_status,
  output logic [15:0]       pkt_ok_cnt,
  output logic [15:0]       pkt_err_cnt
);

  typedef enum logic [2:0] {
    HUNT, TS, CHN, LEN, PAYLOAD, INFO, TRAILER, DROP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  match_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [8:0]  sample_cnt;
  logic [8:0]  sample_nxt;
  logic [8:0]  len_eff;
  logic        info_hi_nz;
  logic        accept;
  logic        hdr_hit;
  logic        word_end;
  logic        last_word;
  logic        in_pkt;
  logic        trunc;
  logic        done_d;
  logic [1:0]  status_d;

  // Only the 4th byte of a word needs the output register, so only it can stall.
  assign s_tready   = (state_q != PAYLOAD) || !(byte_idx == 2'd3 && m_tvalid && !m_tready);
  assign accept     = s_tvalid && s_tready;
  assign hdr_hit    = (s_tdata == HDR_WORD[{match_idx, 3'b000} +: 8]);
  assign len_eff    = (pkt_len == 8'd0) ? 9'd256 : {1'b0, pkt_len};
  assign sample_nxt = sample_cnt + 9'd1;
  assign word_end   = (byte_idx == 2'd3);
  assign last_word  = (sample_nxt == len_eff);
  assign in_pkt     = (state_q == TS) || (state_q == CHN) || (state_q == LEN) ||
                      (state_q == PAYLOAD) || (state_q == INFO);
  assign trunc      = accept && s_tlast && in_pkt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    status_d = 2'd0;
    if (trunc) begin
      state_d  = HUNT;
      done_d   = 1'b1;
      status_d = 2'd1;
    end else if (accept) begin
      case (state_q)
        HUNT:    if (!s_tlast && hdr_hit && match_idx == 2'd3) state_d = TS;
        TS:      if (word_end) state_d = CHN;
        CHN:     state_d = LEN;
        LEN:     state_d = PAYLOAD;
        PAYLOAD: if (word_end && last_word) state_d = INFO;
        INFO:    if (word_end) state_d = TRAILER;
        TRAILER: begin
          done_d  = 1'b1;
          state_d = s_tlast ? HUNT : DROP;
          if (s_tlast && s_tdata == 8'h00) status_d = info_hi_nz ? 2'd3 : 2'd0;
          else                             status_d = 2'd2;
        end
        DROP:    if (s_tlast) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_idx       <= 2'd0;
      byte_idx        <= 2'd0;
      word_buf        <= 24'd0;
      sample_cnt      <= 9'd0;
      info_hi_nz      <= 1'b0;
      m_tdata         <= '0;
      m_tuser         <= 8'd0;
      m_tvalid        <= 1'b0;
      m_tlast         <= 1'b0;
      meta_valid      <= 1'b0;
      pkt_timestamp   <= 32'd0;
      pkt_len         <= 8'd0;
      pkt_error_flags <= 16'd0;
      pkt_done        <= 1'b0;
      pkt_status      <= 2'd0;
    end else begin
      meta_valid <= 1'b0;
      pkt_done   <= done_d;
      if (done_d) pkt_status <= status_d;
      if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
      if (trunc) begin
        // Partial word is dropped; a held word still goes out, marked as the last one.
        byte_idx <= 2'd0;
        if (m_tvalid && !m_tready) m_tlast <= 1'b1;
      end else if (accept) begin
        case (state_q)
          HUNT: begin
            if (s_tlast)      match_idx <= 2'd0;
            else if (hdr_hit) match_idx <= match_idx + 2'd1;
            else              match_idx <= (s_tdata == HDR_WORD[7:0]) ? 2'd1 : 2'd0;
          end
          TS: begin
            pkt_timestamp[{byte_idx, 3'b000} +: 8] <= s_tdata;
            byte_idx <= byte_idx + 2'd1;
          end
          CHN: m_tuser <= s_tdata;
          LEN: begin
            pkt_len    <= s_tdata;
            meta_valid <= 1'b1;
            sample_cnt <= 9'd0;
            info_hi_nz <= 1'b0;
            byte_idx   <= 2'd0;
          end
          PAYLOAD: begin
            if (word_end) begin
              m_tdata    <= {s_tdata, word_buf};
              m_tvalid   <= 1'b1;
              m_tlast    <= last_word;
              sample_cnt <= sample_nxt;
              byte_idx   <= 2'd0;
            end else begin
              word_buf[{byte_idx, 3'b000} +: 8] <= s_tdata;
              byte_idx <= byte_idx + 2'd1;
            end
          end
          INFO: begin
            if (!byte_idx[1])           pkt_error_flags[{byte_idx[0], 3'b000} +: 8] <= s_tdata;
            else if (s_tdata != 8'h00)  info_hi_nz <= 1'b1;
            byte_idx <= byte_idx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DEPKT_STATS_EN
  logic [15:0] ok_q;
  logic [15:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q  <= 16'd0;
      err_q <= 16'd0;
    end else if (pkt_done) begin
      if (pkt_status == 2'd0) begin
        if (ok_q != 16'hFFFF) ok_q <= ok_q + 16'd1;
      end else begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      end
    end
  end

  assign pkt_ok_cnt  = ok_q;
  assign pkt_err_cnt = err_q;
`else
  assign pkt_ok_cnt  = 16'd0;
  assign pkt_err_cnt = 16'd0;
`endif

endmodule
